hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline controller for the 5-stage core (F/D/X/M/W). Keeps a shadow copy of the instruction word in D/X/M/W.
//  Detects RAW hazards and drives stall/bubble/flush controls into fetch, PCMux and decode.
//  Drives operand-forward selects into execute.
//  Counts stall and flush cycles for perf logging.
// PARAMETERS
//  CNT_W      16            width of perf counters stall_cnt/flush_cnt
//  NOP_INST   32'h00000013  word injected as a bubble (addi x0,x0,0)
//  STALL_MAX  3             longest legal consecutive stall run; a longer run sets err
// PORTS
//  clk         in   1      core clock, posedge
//  reset       in   1      synchronous, active-high
//  inst_f      in   32     word fetched into the F/D register this cycle
//  br_taken_x  in   1      branch/jump in X redirects the PC this cycle
//  stall_f     out  1      1 = hold PC and the F/D instruction register
//  bubble_x    out  1      1 = load NOP_INST into the D/X register
//  flush_d     out  1      1 = load NOP_INST into the F/D register
//  fwd_a_sel   out  2      X operand A: 00 regfile, 01 alu_m, 10 wb_w
//  fwd_b_sel   out  2      X operand B / store data: encoding as fwd_a_sel
//  fwd_d_a     out  1      1 = D rs1 read takes wb_w (regfile is not write-through)
//  fwd_d_b     out  1      1 = D rs2 read takes wb_w
//  stall_cnt   out  CNT_W  cycles with stall_f=1, saturating
//  flush_cnt   out  CNT_W  cycles with br_taken_x=1, saturating
//  err         out  1      sticky: stall run exceeded STALL_MAX
// BEHAVIOUR
//  Reset: inst_d/x/m/w <= NOP_INST. All outputs 0, counters 0, err 0.
//  Field rules: rd=[11:7], rs1=[19:15], rs2=[24:20].
//   writes(i) = opcode in {OP,OP_IMM,LOAD,LUI,AUIPC,JAL,JALR} && rd!=0.
//   use1(i) = opcode not in {LUI,AUIPC,JAL}. use2(i) = opcode in {OP,STORE,BRANCH}.
//   Source s of i hits producer p iff writes(p) && use_s(i) && rs_s(i)==rd(p).
//  Shadow advance, per posedge, evaluated in priority order:
//   flush  (br_taken_x): inst_d<=NOP, inst_x<=NOP, inst_m<=inst_x, inst_w<=inst_m.
//   stall  (stall_f): inst_d holds, inst_x<=NOP, inst_m<=inst_x, inst_w<=inst_m.
//   normal: inst_d<=inst_f, inst_x<=inst_d, inst_m<=inst_x, inst_w<=inst_m.
//  Control outputs are combinational from the shadow registers and br_taken_x:
//   flush_d = br_taken_x.
//   bubble_x = stall_f | br_taken_x.
//   stall_f = hazard & ~br_taken_x. A flush kills the stalled D word, so no stall.
//  Forward selects describe inst_x. Priority: M hit -> 01, else W hit -> 10, else 00.
//   fwd_d_a/b = D hits W.
//  An X-vs-M hit where M is a LOAD never occurs; it is prevented by the load-use stall.
//  Stall run counter: resets to 0 on any cycle with stall_f=0.
//   err <= 1 when the run reaches STALL_MAX+1. err clears only on reset.
//  Counters saturate at all-ones and do not wrap. Reset mid-stall or mid-flush returns to the reset state next edge.
// CONFIGURATION
//  HAZARD_CTRL_FORWARD_EN defined:
//   hazard = inst_x is LOAD && D hits X. Only load-use stalls: exactly 1 cycle.
//   Forward selects are live.
//  HAZARD_CTRL_FORWARD_EN undefined:
//   hazard = D hits X, M or W.
//   fwd_a_sel, fwd_b_sel, fwd_d_a, fwd_d_b are tied 0. Stall run is at most 3 cycles.
// STRUCTURE
//  Shared package/header (constants.v): opcode constants and NOP_INST. Also the fwd select encodings FWD_RF=00, FWD_M=01, FWD_W=10.
//  Sub-module hazard_fields: combinational, maps 32-bit inst -> rd, rs1, rs2, writes, use1, use2.
//   Four instances: D, X, M, W.
//  Top holds the shadow registers, hit comparators, counters and err.
// TESTING
//  1. FWD_EN. lw x5,0(x1); add x6,x5,x2
//     -> stall_f=1 and bubble_x=1 for exactly 1 cycle.
//     -> add in X: fwd_a_sel=10. stall_cnt=1.
//  2. FWD_EN. add x3,x1,x2; sub x4,x3,x3
//     -> no stall. sub in X: fwd_a_sel=fwd_b_sel=01.
//  3. No FWD_EN. add x3,x1,x2; or x4,x3,x0
//     -> stall_f=1 for 3 cycles. err stays 0.
//  4. Writes and reads to x0, e.g. addi x0,x0,5; add x7,x0,x0
//     -> no stall, all fwd selects 00.
//  5. br_taken_x=1 while a load-use stall is pending
//     -> stall_f=0, flush_d=1, bubble_x=1. flush_cnt+1. inst_d=inst_x=NOP next edge.
//  6. Force inst_d to hit X for 5 cycles, then assert reset mid-run
//     -> err=1 on the 4th stall cycle. Reset edge -> all outputs and counters 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard controller: RV32 opcodes, the bubble word,
// forward-select encodings and the source-vs-producer hit test.
package hazard_ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    function automatic logic src_hit(input logic use_s, input logic [4:0] rs,
                                     input logic wr, input logic [4:0] rd);
        return use_s && wr && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fields.sv
// Combinational decode of one shadow instruction word into the register
// fields and the writes/use1/use2 flags used by the hazard comparators.
module hazard_fields
    import hazard_ctrl_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic        writes_o,
    output logic        use1_o,
    output logic        use2_o
);

    logic [6:0] opc;
    logic       unused_bits;

    assign opc         = inst_i[6:0];
    assign rd_o        = inst_i[11:7];
    assign rs1_o       = inst_i[19:15];
    assign rs2_o       = inst_i[24:20];
    assign unused_bits = ^{inst_i[31:25], inst_i[14:12]};

    always_comb begin
        writes_o = 1'b0;
        use1_o   = 1'b1;
        use2_o   = 1'b0;
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR: writes_o = (rd_o != 5'd0);
            default:                      writes_o = 1'b0;
        endcase
        if (opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL)
            use1_o = 1'b0;
        if (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH)
            use2_o = 1'b1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: shadow D/X/M/W words, stall/flush
// control, operand forwarding and perf counters. Build macro: HAZARD_CTRL_FORWARD_EN.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int          CNT_W     = 16,
    parameter logic [31:0] NOP_INST  = NOP_WORD,
    parameter int          STALL_MAX = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst_f,
    input  logic             br_taken_x,
    output logic             stall_f,
    output logic             bubble_x,
    output logic             flush_d,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             fwd_d_a,
    output logic             fwd_d_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err
);

    localparam int RUN_W = $clog2(STALL_MAX + 2);

    logic [31:0]      inst_d_q, inst_x_q, inst_m_q, inst_w_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             err_q, err_d;

    // Stage index: 0 = D, 1 = X, 2 = M, 3 = W
    logic [31:0] stage_inst [4];
    logic [4:0]  rd [4];
    logic [4:0]  rs1 [4];
    logic [4:0]  rs2 [4];
    logic [3:0]  wr, use1, use2;
    logic        hazard, unused_fields;

    assign stage_inst[0] = inst_d_q;
    assign stage_inst[1] = inst_x_q;
    assign stage_inst[2] = inst_m_q;
    assign stage_inst[3] = inst_w_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fields
            hazard_fields u_fields (
                .inst_i   (stage_inst[gi]),
                .rd_o     (rd[gi]),
                .rs1_o    (rs1[gi]),
                .rs2_o    (rs2[gi]),
                .writes_o (wr[gi]),
                .use1_o   (use1[gi]),
                .use2_o   (use2[gi])
            );
        end
    endgenerate

    assign unused_fields = ^{wr[0], use1[3:1], use2[3:1], rd[0],
                             rs1[2], rs1[3], rs2[2], rs2[3]};

    function automatic logic hits(input int c, input int p);
        return src_hit(use1[c], rs1[c], wr[p], rd[p]) |
               src_hit(use2[c], rs2[c], wr[p], rd[p]);
    endfunction

`ifdef HAZARD_CTRL_FORWARD_EN
    assign hazard = (inst_x_q[6:0] == OPC_LOAD) && hits(0, 1);

    always_comb begin
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (src_hit(use1[1], rs1[1], wr[2], rd[2]))      fwd_a_sel = FWD_M;
        else if (src_hit(use1[1], rs1[1], wr[3], rd[3])) fwd_a_sel = FWD_W;
        if (src_hit(use2[1], rs2[1], wr[2], rd[2]))      fwd_b_sel = FWD_M;
        else if (src_hit(use2[1], rs2[1], wr[3], rd[3])) fwd_b_sel = FWD_W;
    end

    assign fwd_d_a = src_hit(use1[0], rs1[0], wr[3], rd[3]);
    assign fwd_d_b = src_hit(use2[0], rs2[0], wr[3], rd[3]);
`else
    // Without forwarding D must wait until every in-flight producer has retired.
    assign hazard    = hits(0, 1) | hits(0, 2) | hits(0, 3);
    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;
    assign fwd_d_a   = 1'b0;
    assign fwd_d_b   = 1'b0;
`endif

    assign stall_f  = hazard & ~br_taken_x;
    assign bubble_x = stall_f | br_taken_x;
    assign flush_d  = br_taken_x;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        run_d       = '0;
        err_d       = err_q;
        if (stall_f && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (br_taken_x && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        if (stall_f) begin
            run_d = (run_q == RUN_W'(STALL_MAX + 1)) ? run_q : run_q + RUN_W'(1);
            if (run_q >= RUN_W'(STALL_MAX)) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_d_q    <= NOP_INST;
            inst_x_q    <= NOP_INST;
            inst_m_q    <= NOP_INST;
            inst_w_q    <= NOP_INST;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            run_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            inst_m_q <= inst_x_q;
            inst_w_q <= inst_m_q;
            if (br_taken_x) begin
                inst_d_q <= NOP_INST;
                inst_x_q <= NOP_INST;
            end else if (stall_f) begin
                inst_x_q <= NOP_INST;
            end else begin
                inst_d_q <= inst_f;
                inst_x_q <= inst_d_q;
            end
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            run_q       <= run_d;
            err_q       <= err_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic,
// checked against a pipeline-occupancy model. Honours HAZARD_CTRL_FORWARD_EN.
module tb_hazard_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [6:0] OP = 7'h33, OPI = 7'h13, LD = 7'h03, ST = 7'h23,
                           BR = 7'h63, LUI = 7'h37, AUI = 7'h17, JAL = 7'h6f, JALR = 7'h67;

    logic        clk = 1'b0;
    logic        reset, br;
    logic [31:0] inst_f;

    logic        stall_f, bubble_x, flush_d, fwd_d_a, fwd_d_b, err;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt, flush_cnt;
    logic        e_stall_f, e_bubble_x, e_flush_d, e_fwd_d_a, e_fwd_d_b, e_err;
    logic [1:0]  e_fwd_a_sel, e_fwd_b_sel;
    logic [3:0]  e_stall_cnt, e_flush_cnt;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .inst_f(inst_f), .br_taken_x(br),
        .stall_f(stall_f), .bubble_x(bubble_x), .flush_d(flush_d),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .fwd_d_a(fwd_d_a), .fwd_d_b(fwd_d_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err(err)
    );

    // Narrow counters and a shorter stall limit expose saturation and err.
    hazard_ctrl #(.CNT_W(4), .STALL_MAX(2)) dut_e (
        .clk(clk), .reset(reset), .inst_f(inst_f), .br_taken_x(br),
        .stall_f(e_stall_f), .bubble_x(e_bubble_x), .flush_d(e_flush_d),
        .fwd_a_sel(e_fwd_a_sel), .fwd_b_sel(e_fwd_b_sel),
        .fwd_d_a(e_fwd_d_a), .fwd_d_b(e_fwd_d_b),
        .stall_cnt(e_stall_cnt), .flush_cnt(e_flush_cnt), .err(e_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst; logic br, rst;
        logic stall, bubble, flush; logic [1:0] fa, fb; logic da, db;
        int scnt, fcnt; logic err; int scnt2, fcnt2; logic err2;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0, failures = 0, txn = 0, n_stall_obs = 0;

    logic [31:0] md, mx, mm, mw;
    int   ms, mf, ms2, mf2, run;
    logic me, me2;

    function automatic bit m_wr(input logic [31:0] i);
        return (i[6:0] inside {OP, OPI, LD, LUI, AUI, JAL, JALR}) && i[11:7] != 5'd0;
    endfunction
    function automatic bit m_hit(input logic [31:0] c, input logic [31:0] p, input int s);
        logic [4:0] rs;
        bit us;
        rs = (s == 1) ? c[19:15] : c[24:20];
        us = (s == 1) ? !(c[6:0] inside {LUI, AUI, JAL}) : (c[6:0] inside {OP, ST, BR});
        return m_wr(p) && us && rs == p[11:7];
    endfunction
    function automatic bit m_any(input logic [31:0] c, input logic [31:0] p);
        return m_hit(c, p, 1) || m_hit(c, p, 2);
    endfunction
    function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), op};
    endfunction

    task automatic mreset();
        md = NOP; mx = NOP; mm = NOP; mw = NOP;
        ms = 0; mf = 0; ms2 = 0; mf2 = 0; run = 0; me = 0; me2 = 0;
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s txn=%0d actual=%0h required=%0h", nm, txn, act, exp);
        end
    endtask

    // One cycle: drive inputs, predict the response, advance the model.
    task automatic step(input logic [31:0] inst, input logic b, input logic r);
        exp_t e;
        bit hz;
        inst_f = inst; br = b; reset = r;
`ifdef HAZARD_CTRL_FORWARD_EN
        hz = (mx[6:0] == LD) && m_any(md, mx);
        e.fa = m_hit(mx, mm, 1) ? 2'd1 : m_hit(mx, mw, 1) ? 2'd2 : 2'd0;
        e.fb = m_hit(mx, mm, 2) ? 2'd1 : m_hit(mx, mw, 2) ? 2'd2 : 2'd0;
        e.da = m_hit(md, mw, 1);
        e.db = m_hit(md, mw, 2);
`else
        hz = m_any(md, mx) || m_any(md, mm) || m_any(md, mw);
        e.fa = 2'd0; e.fb = 2'd0; e.da = 1'b0; e.db = 1'b0;
`endif
        e.inst = inst; e.br = b; e.rst = r;
        e.stall = hz && !b; e.bubble = e.stall || b; e.flush = b;
        e.scnt = ms; e.fcnt = mf; e.err = me; e.scnt2 = ms2; e.fcnt2 = mf2; e.err2 = me2;
        sbq.push_back(e);
        if (r) mreset();
        else begin
            mw = mm; mm = mx;
            if (b) begin md = NOP; mx = NOP; end
            else if (e.stall) mx = NOP;
            else begin mx = md; md = inst; end
            if (e.stall && ms < 65535) ms++;
            if (e.stall && ms2 < 15) ms2++;
            if (b && mf < 65535) mf++;
            if (b && mf2 < 15) mf2++;
            if (e.stall) begin
                run++;
                if (run > 3) me = 1'b1;
                if (run > 2) me2 = 1'b1;
            end else run = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(NOP, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            txn++;
            if (stall_f === 1'b1) n_stall_obs++;
            $display("txn %0d inst=%h br=%b rst=%b stall=%b bub=%b fl=%b fa=%0d fb=%0d da=%b db=%b sc=%0d fc=%0d err=%b sc2=%0d fc2=%0d err2=%b",
                     txn, e.inst, e.br, e.rst, stall_f, bubble_x, flush_d, fwd_a_sel, fwd_b_sel,
                     fwd_d_a, fwd_d_b, stall_cnt, flush_cnt, err, e_stall_cnt, e_flush_cnt, e_err);
            cmp("stall_f", 32'(stall_f), 32'(e.stall));
            cmp("bubble_x", 32'(bubble_x), 32'(e.bubble));
            cmp("flush_d", 32'(flush_d), 32'(e.flush));
            cmp("fwd_a_sel", 32'(fwd_a_sel), 32'(e.fa));
            cmp("fwd_b_sel", 32'(fwd_b_sel), 32'(e.fb));
            cmp("fwd_d_a", 32'(fwd_d_a), 32'(e.da));
            cmp("fwd_d_b", 32'(fwd_d_b), 32'(e.db));
            cmp("stall_cnt", 32'(stall_cnt), 32'(e.scnt));
            cmp("flush_cnt", 32'(flush_cnt), 32'(e.fcnt));
            cmp("err", 32'(err), 32'(e.err));
            cmp("e_stall_f", 32'(e_stall_f), 32'(e.stall));
            cmp("e_stall_cnt", 32'(e_stall_cnt), 32'(e.scnt2));
            cmp("e_flush_cnt", 32'(e_flush_cnt), 32'(e.fcnt2));
            cmp("e_err", 32'(e_err), 32'(e.err2));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout txn=%0d", txn);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        logic [6:0] ops [9];
        ops = '{OP, OPI, LD, ST, BR, LUI, AUI, JAL, JALR};
        reset = 1'b1; br = 1'b0; inst_f = NOP;
        repeat (2) @(posedge clk);
        #1;
        mreset();
        nops(2);

        // Writes to / reads of x0 never stall or forward.
        step(mk(OPI, 0, 0, 5), 1'b0, 1'b0);
        step(mk(OP, 7, 0, 0), 1'b0, 1'b0);
        nops(4);

`ifdef HAZARD_CTRL_FORWARD_EN
        // Load-use: one stall, then forward from W.
        base = n_stall_obs;
        step(mk(LD, 5, 1, 0), 1'b0, 1'b0);
        step(mk(OP, 6, 5, 2), 1'b0, 1'b0);
        nops(5);
        cmp("t1_stall_run", 32'(n_stall_obs - base), 32'd1);
        // ALU-ALU: forward from M on both operands, no stall.
        base = n_stall_obs;
        step(mk(OP, 3, 1, 2), 1'b0, 1'b0);
        step(mk(OP, 4, 3, 3), 1'b0, 1'b0);
        nops(4);
        cmp("t2_stall_run", 32'(n_stall_obs - base), 32'd0);
        // Branch overrides a pending load-use stall.
        step(mk(LD, 5, 1, 0), 1'b0, 1'b0);
        step(mk(OP, 6, 5, 2), 1'b0, 1'b0);
        step(NOP, 1'b1, 1'b0);
        nops(4);
`else
        // RAW without forwarding: three-cycle stall, err on the default limit stays 0.
        base = n_stall_obs;
        step(mk(OP, 3, 1, 2), 1'b0, 1'b0);
        step(mk(OP, 4, 3, 0), 1'b0, 1'b0);
        nops(6);
        cmp("t3_stall_run", 32'(n_stall_obs - base), 32'd3);
        // Branch overrides a pending stall.
        step(mk(OP, 3, 1, 2), 1'b0, 1'b0);
        step(mk(OP, 5, 3, 3), 1'b0, 1'b0);
        step(NOP, 1'b1, 1'b0);
        nops(4);
        // Reset in the middle of a stall run.
        step(mk(OP, 3, 1, 2), 1'b0, 1'b0);
        step(mk(OP, 4, 3, 0), 1'b0, 1'b0);
        nops(1);
        step(NOP, 1'b0, 1'b1);
        nops(3);
`endif

        // Random traffic on a small register set to keep hazards frequent.
        for (int i = 0; i < 900; i++) begin
            logic [31:0] w;
            logic [6:0]  o;
            o = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            w = mk(o, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            step(w, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
        end

        @(negedge clk);
        cmp("sb_drain", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
